// File: rtl/cvxif_initiator.sv
// Single-outstanding CV-X-IF offload initiator: issues one command, commits or
// kills it, collects the matching result and returns a status to the requester.
module cvxif_initiator #(
  parameter int XLEN          = 64,
  parameter int IdWidth       = 3,
  parameter int TimeoutCycles = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // command side
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [31:0]        cmd_instr_i,
  input  logic [XLEN-1:0]    cmd_rs1_i,
  input  logic [XLEN-1:0]    cmd_rs2_i,
  input  logic               cmd_kill_i,
  // issue
  output logic               x_issue_valid_o,
  input  logic               x_issue_ready_i,
  input  logic               x_issue_accept_i,
  input  logic               x_issue_writeback_i,
  output logic [31:0]        x_issue_instr_o,
  output logic [XLEN-1:0]    x_issue_rs1_o,
  output logic [XLEN-1:0]    x_issue_rs2_o,
  output logic [IdWidth-1:0] x_issue_id_o,
  // commit
  output logic               x_commit_valid_o,
  output logic [IdWidth-1:0] x_commit_id_o,
  output logic               x_commit_kill_o,
  // result
  input  logic               x_result_valid_i,
  output logic               x_result_ready_o,
  input  logic [IdWidth-1:0] x_result_id_i,
  input  logic [XLEN-1:0]    x_result_data_i,
  input  logic [4:0]         x_result_rd_i,
  input  logic               x_result_we_i,
  input  logic               x_result_exc_i,
  // response
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [XLEN-1:0]    rsp_data_o,
  output logic [4:0]         rsp_rd_o,
  output logic               rsp_we_o,
  output logic               rsp_exc_o,
  output logic [1:0]         rsp_status_o
);

  localparam int TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  localparam logic [1:0] StOk       = 2'd0;
  localparam logic [1:0] StRejected = 2'd1;
  localparam logic [1:0] StKilled   = 2'd2;
  localparam logic [1:0] StTimeout  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COMMIT,
    S_WAIT_RES,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_instr;
  logic [XLEN-1:0]     r_rs1;
  logic [XLEN-1:0]     r_rs2;
  logic [IdWidth-1:0]  r_id;
  logic [IdWidth-1:0]  r_id_cnt;
  logic                r_wb;
  logic [TmoW-1:0]     r_tmo_cnt;
  logic [XLEN-1:0]     r_rsp_data;
  logic [4:0]          r_rsp_rd;
  logic                r_rsp_we;
  logic                r_rsp_exc;
  logic [1:0]          r_rsp_status;
  logic                w_res_match;
  logic                w_tmo_hit;

  assign w_res_match = x_result_valid_i && (x_result_id_i == r_id);
  assign w_tmo_hit   = (r_tmo_cnt == TmoLast);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:     if (cmd_valid_i) w_state_next = S_ISSUE;
      S_ISSUE:    if (x_issue_ready_i) w_state_next = x_issue_accept_i ? S_COMMIT : S_RESP;
      S_COMMIT:   w_state_next = (cmd_kill_i || !r_wb) ? S_RESP : S_WAIT_RES;
      S_WAIT_RES: if (w_res_match || w_tmo_hit) w_state_next = S_RESP;
      S_RESP:     if (rsp_ready_i) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_instr      <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_id         <= '0;
      r_id_cnt     <= '0;
      r_wb         <= 1'b0;
      r_tmo_cnt    <= '0;
      r_rsp_data   <= '0;
      r_rsp_rd     <= '0;
      r_rsp_we     <= 1'b0;
      r_rsp_exc    <= 1'b0;
      r_rsp_status <= StOk;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid_i) begin
          r_instr <= cmd_instr_i;
          r_rs1   <= cmd_rs1_i;
          r_rs2   <= cmd_rs2_i;
          r_id    <= r_id_cnt;
        end
        S_ISSUE: if (x_issue_ready_i) begin
          r_wb <= x_issue_writeback_i;
          if (!x_issue_accept_i) begin
            {r_rsp_data, r_rsp_rd, r_rsp_we, r_rsp_exc} <= '0;
            r_rsp_status <= StRejected;
          end
        end
        S_COMMIT: begin
          // counter starts from zero on the first WAIT_RES cycle
          r_tmo_cnt <= '0;
          if (cmd_kill_i || !r_wb) begin
            {r_rsp_data, r_rsp_rd, r_rsp_we, r_rsp_exc} <= '0;
            r_rsp_status <= cmd_kill_i ? StKilled : StOk;
          end
        end
        S_WAIT_RES: begin
          r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
          // a matching result takes priority over an expiring timeout
          if (w_res_match) begin
            r_rsp_data   <= x_result_data_i;
            r_rsp_rd     <= x_result_rd_i;
            r_rsp_we     <= x_result_we_i;
            r_rsp_exc    <= x_result_exc_i;
            r_rsp_status <= StOk;
          end else if (w_tmo_hit) begin
            {r_rsp_data, r_rsp_rd, r_rsp_we, r_rsp_exc} <= '0;
            r_rsp_status <= StTimeout;
          end
        end
        S_RESP: if (rsp_ready_i) r_id_cnt <= r_id_cnt + IdWidth'(1);
        default: ;
      endcase
    end
  end

  assign cmd_ready_o      = (r_state == S_IDLE);
  assign x_issue_valid_o  = (r_state == S_ISSUE);
  assign x_issue_instr_o  = r_instr;
  assign x_issue_rs1_o    = r_rs1;
  assign x_issue_rs2_o    = r_rs2;
  assign x_issue_id_o     = r_id;
  assign x_commit_valid_o = (r_state == S_COMMIT);
  assign x_commit_id_o    = r_id;
  assign x_commit_kill_o  = (r_state == S_COMMIT) && cmd_kill_i;
  assign x_result_ready_o = (r_state == S_WAIT_RES);
  assign rsp_valid_o      = (r_state == S_RESP);
  assign rsp_data_o       = r_rsp_data;
  assign rsp_rd_o         = r_rsp_rd;
  assign rsp_we_o         = r_rsp_we;
  assign rsp_exc_o        = r_rsp_exc;
  assign rsp_status_o     = r_rsp_status;

endmodule

// File: tb/tb_cvxif_initiator.sv
// Randomised scoreboard bench for cvxif_initiator: stimulus pushes expected
// issue payloads and responses, a negedge monitor pops and compares them.
module tb_cvxif_initiator;
  localparam int XLEN = 64;
  localparam int IDW  = 3;
  localparam int TMO  = 16;
  localparam logic [1:0] OK = 2'd0, REJ = 2'd1, KIL = 2'd2, TOUT = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid_i = 0, cmd_ready_o, cmd_kill_i = 0;
  logic [31:0] cmd_instr_i = '0;
  logic [XLEN-1:0] cmd_rs1_i = '0, cmd_rs2_i = '0;
  logic x_issue_valid_o, x_issue_ready_i = 0, x_issue_accept_i = 0, x_issue_writeback_i = 0;
  logic [31:0] x_issue_instr_o;
  logic [XLEN-1:0] x_issue_rs1_o, x_issue_rs2_o;
  logic [IDW-1:0] x_issue_id_o, x_commit_id_o;
  logic x_commit_valid_o, x_commit_kill_o;
  logic x_result_valid_i = 0, x_result_ready_o, x_result_we_i = 0, x_result_exc_i = 0;
  logic [IDW-1:0] x_result_id_i = '0;
  logic [XLEN-1:0] x_result_data_i = '0;
  logic [4:0] x_result_rd_i = '0;
  logic rsp_valid_o, rsp_ready_i = 0, rsp_we_o, rsp_exc_o;
  logic [XLEN-1:0] rsp_data_o;
  logic [4:0] rsp_rd_o;
  logic [1:0] rsp_status_o;

  cvxif_initiator #(.XLEN(XLEN), .IdWidth(IDW), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_instr_i(cmd_instr_i),
    .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i), .cmd_kill_i(cmd_kill_i),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
    .x_issue_instr_o(x_issue_instr_o), .x_issue_rs1_o(x_issue_rs1_o),
    .x_issue_rs2_o(x_issue_rs2_o), .x_issue_id_o(x_issue_id_o),
    .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
    .x_commit_kill_o(x_commit_kill_o),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
    .x_result_rd_i(x_result_rd_i), .x_result_we_i(x_result_we_i), .x_result_exc_i(x_result_exc_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_rd_o(rsp_rd_o), .rsp_we_o(rsp_we_o), .rsp_exc_o(rsp_exc_o), .rsp_status_o(rsp_status_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [IDW-1:0]  id;
  } iss_t;

  typedef struct {
    logic [1:0]      status;
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
    logic            exc;
    bit              chk_data;
    bit              chk_flags;
    int              lat;
    bit              exp_commit;
    bit              exp_wait;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [IDW-1:0] exp_id = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    iss_t cur_iss;
    rsp_t cur_rsp;
    bit commit_seen = 0, wait_seen = 0, prev_commit = 0, prev_iss = 0, prev_rsp = 0;
    int c0 = 0;
    cur_iss = '{default: '0};
    cur_rsp = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        commit_seen = 0; wait_seen = 0; prev_commit = 0; prev_iss = 0; prev_rsp = 0;
      end else begin
        check("onehot_status", $countones({cmd_ready_o, x_issue_valid_o, x_commit_valid_o,
                                           x_result_ready_o, rsp_valid_o}), 1);
        if (cmd_valid_i && cmd_ready_o) begin
          c0 = cyc; commit_seen = 0; wait_seen = 0;
        end
        if (x_issue_valid_o) begin
          if (!prev_iss) begin
            if (iss_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL issue_unexpected: issue seen, expected none");
            end else cur_iss = iss_q.pop_front();
          end
          check("issue_instr", x_issue_instr_o, cur_iss.instr);
          check("issue_rs1", x_issue_rs1_o, cur_iss.rs1);
          check("issue_rs2", x_issue_rs2_o, cur_iss.rs2);
          check("issue_id", x_issue_id_o, cur_iss.id);
        end
        if (x_commit_valid_o) begin
          commit_seen = 1;
          check("commit_single_cycle", prev_commit, 0);
          check("commit_id", x_commit_id_o, cur_iss.id);
          check("commit_kill", x_commit_kill_o, (rsp_q.size() > 0 && rsp_q[0].status == KIL));
        end
        if (x_result_ready_o) wait_seen = 1;
        if (rsp_valid_o) begin
          if (!prev_rsp) begin
            if (rsp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL rsp_unexpected: response seen, expected none");
            end else begin
              cur_rsp = rsp_q.pop_front();
              check("rsp_latency", cyc - c0, cur_rsp.lat);
              check("rsp_commit_seen", commit_seen, cur_rsp.exp_commit);
              check("rsp_wait_seen", wait_seen, cur_rsp.exp_wait);
            end
          end
          check("rsp_status", rsp_status_o, cur_rsp.status);
          if (cur_rsp.chk_data) check("rsp_data", rsp_data_o, cur_rsp.data);
          if (cur_rsp.chk_flags) begin
            check("rsp_rd", rsp_rd_o, cur_rsp.rd);
            check("rsp_we", rsp_we_o, cur_rsp.we);
            check("rsp_exc", rsp_exc_o, cur_rsp.exc);
          end
        end
        prev_commit = x_commit_valid_o;
        prev_iss = x_issue_valid_o;
        prev_rsp = rsp_valid_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_now(input string what);
    n_checks++; n_fail++;
    $display("FAIL %s: DUT did not respond within the cycle bound", what);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic send_cmd(input logic [31:0] instr, input logic [XLEN-1:0] rs1, rs2, output bit ok);
    ok = 0;
    for (int k = 0; k < 20 && !cmd_ready_o; k++) step();
    if (!cmd_ready_o) begin finish_now("cmd_ready_wait"); return; end
    cmd_valid_i = 1; cmd_instr_i = instr; cmd_rs1_i = rs1; cmd_rs2_i = rs2;
    step();
    cmd_valid_i = 0;
    ok = 1;
  endtask

  // One full transaction. res_delay counts cycles from WAIT_RES entry (-1: never).
  task automatic run_txn(input logic [31:0] instr, input logic [XLEN-1:0] rs1, rs2,
                         input bit accept, wb, kill, input int issue_delay, res_delay, stray_at,
                         input bit r_we, r_exc, input int rsp_hold);
    iss_t is;
    rsp_t e;
    bit ok;
    is.instr = instr; is.rs1 = rs1; is.rs2 = rs2; is.id = exp_id;
    iss_q.push_back(is);
    e = '{default: '0};
    e.exp_commit = accept;
    e.exp_wait = accept && !kill && wb;
    if (!accept) begin
      e.status = REJ; e.chk_data = 1; e.chk_flags = 1; e.lat = issue_delay + 2;
    end else if (kill) begin
      e.status = KIL; e.lat = issue_delay + 3;
    end else if (!wb) begin
      e.status = OK; e.chk_data = 1; e.lat = issue_delay + 3;
    end else if (res_delay >= 0 && res_delay < TMO) begin
      e.status = OK; e.data = rs1 + rs2; e.rd = instr[11:7]; e.we = r_we; e.exc = r_exc;
      e.chk_data = 1; e.chk_flags = 1; e.lat = issue_delay + 3 + res_delay + 1;
    end else begin
      e.status = TOUT; e.chk_data = 1; e.lat = issue_delay + 3 + TMO;
    end
    rsp_q.push_back(e);

    send_cmd(instr, rs1, rs2, ok);
    if (!ok) return;
    x_issue_accept_i = accept; x_issue_writeback_i = wb;
    repeat (issue_delay) step();
    x_issue_ready_i = 1;
    step();
    x_issue_ready_i = 0; x_issue_accept_i = 0; x_issue_writeback_i = 0;
    if (accept) begin
      cmd_kill_i = kill;
      step();
      cmd_kill_i = 0;
      if (!kill && wb) begin
        for (int c = 0; c < TMO + 4; c++) begin
          if (rsp_valid_o) break;
          if (c == res_delay) begin
            x_result_valid_i = 1; x_result_id_i = exp_id; x_result_data_i = rs1 + rs2;
            x_result_rd_i = instr[11:7]; x_result_we_i = r_we; x_result_exc_i = r_exc;
          end else if (c == stray_at) begin
            x_result_valid_i = 1; x_result_id_i = exp_id + 3'd3;
            x_result_data_i = {$urandom, $urandom}; x_result_rd_i = 5'($urandom);
            x_result_we_i = 1; x_result_exc_i = 1;
          end
          step();
          x_result_valid_i = 0;
        end
      end
    end
    for (int k = 0; k < 8 && !rsp_valid_o; k++) step();
    if (!rsp_valid_o) begin finish_now("rsp_valid_wait"); return; end
    repeat (rsp_hold) step();
    rsp_ready_i = 1;
    step();
    rsp_ready_i = 0;
    exp_id = exp_id + 3'd1;
    $display("txn instr=%08h acc=%0d wb=%0d kill=%0d res_delay=%0d stray=%0d -> expected status %0d",
             instr, accept, wb, kill, res_delay, stray_at, e.status);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, {cmd_ready_o, x_issue_valid_o, x_commit_valid_o, x_commit_kill_o,
                             x_result_ready_o, rsp_valid_o}, 6'b100000);
    check({tag, "_issue_payload"}, {x_issue_instr_o, x_issue_id_o, x_commit_id_o}, 0);
    check({tag, "_issue_rs"}, x_issue_rs1_o | x_issue_rs2_o, 0);
    check({tag, "_rsp_fields"}, {rsp_rd_o, rsp_we_o, rsp_exc_o, rsp_status_o}, 0);
    check({tag, "_rsp_data"}, rsp_data_o, 0);
  endtask

  task automatic reset_in_wait();
    iss_t is;
    bit ok;
    is.instr = $urandom; is.rs1 = {$urandom, $urandom}; is.rs2 = {$urandom, $urandom}; is.id = exp_id;
    iss_q.push_back(is);
    send_cmd(is.instr, is.rs1, is.rs2, ok);
    if (!ok) return;
    x_issue_accept_i = 1; x_issue_writeback_i = 1; x_issue_ready_i = 1;
    step();
    x_issue_ready_i = 0; x_issue_accept_i = 0; x_issue_writeback_i = 0;
    step();
    repeat (3) step();
    check("pre_reset_in_wait", x_result_ready_o, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    exp_id = '0;
    check_idle_outputs("reset_in_wait");
    repeat (4) step();
    check("post_reset_abandoned", {cmd_ready_o, x_commit_valid_o, rsp_valid_o}, 3'b100);
    $display("txn reset during WAIT_RES -> expected IDLE, id 0");
  endtask

  initial begin
    rst_n = 0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst_n = 1;
    step();

    // directed cases: basic writeback, reject, stray id, kill, timeout, no-writeback with backpressure
    run_txn(32'h0000000B, 64'd5, 64'd7, 1, 1, 0, 0, 0, -1, 1, 0, 0);
    run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1, 0, 0, -1, -1, 0, 0, 0);
    run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, 0, 1, 3, 1, 1, 1, 1);
    run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, 1, 0, 0, -1, 0, 0, 0);
    run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, 0, 0, -1, 4, 0, 0, 0);
    run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 0, 0, -1, -1, 0, 0, 10);
    run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, 0, 2, TMO - 1, -1, 1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom % 4) != 0, $urandom_range(0, 1), ($urandom % 5) == 0,
              $urandom_range(0, 3), $urandom_range(0, 19),
              (($urandom % 3) == 0) ? int'($urandom_range(0, 15)) : -1,
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
    end

    reset_in_wait();
    // after reset the id restarts at 0; result lands in the final timeout cycle
    run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, 0, 0, TMO - 1, -1, 1, 1, 2);
    run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, 0, 0, -1, -1, 0, 0, 0);

    repeat (3) step();
    check("queues_drained", rsp_q.size() + iss_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cvxif_initiator.md
CVXIF_INITIATOR -- requirements
Module: cvxif_initiator

Interface
REQ-001 The module SHALL have parameter XLEN, default 64: operand and result width.
REQ-002 The module SHALL have parameter IdWidth, default 3: transaction id width.
REQ-003 The module SHALL have parameter TimeoutCycles, default 1024: maximum cycles spent waiting for a result.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The module SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have the following command ports:
- cmd_valid_i, input, 1 bit
- cmd_ready_o, output, 1 bit
- cmd_instr_i, input, 32 bits
- cmd_rs1_i, input, XLEN bits
- cmd_rs2_i, input, XLEN bits
- cmd_kill_i, input, 1 bit: kill request, sampled in COMMIT.
REQ-007 The module SHALL have the following issue ports:
- x_issue_valid_o, output, 1 bit
- x_issue_ready_i, input, 1 bit
- x_issue_accept_i, input, 1 bit
- x_issue_writeback_i, input, 1 bit
- x_issue_instr_o, output, 32 bits
- x_issue_rs1_o, output, XLEN bits
- x_issue_rs2_o, output, XLEN bits
- x_issue_id_o, output, IdWidth bits.
REQ-008 The module SHALL have the following commit ports:
- x_commit_valid_o, output, 1 bit
- x_commit_id_o, output, IdWidth bits
- x_commit_kill_o, output, 1 bit.
REQ-009 The module SHALL have the following result ports:
- x_result_valid_i, input, 1 bit
- x_result_ready_o, output, 1 bit
- x_result_id_i, input, IdWidth bits
- x_result_data_i, input, XLEN bits
- x_result_rd_i, input, 5 bits
- x_result_we_i, input, 1 bit
- x_result_exc_i, input, 1 bit.
REQ-010 The module SHALL have the following response ports:
- rsp_valid_o, output, 1 bit
- rsp_ready_i, input, 1 bit
- rsp_data_o, output, XLEN bits
- rsp_rd_o, output, 5 bits
- rsp_we_o, output, 1 bit
- rsp_exc_o, output, 1 bit
- rsp_status_o, output, 2 bits, encoded 0 OK, 1 REJECTED, 2 KILLED, 3 TIMEOUT.

Function
REQ-011 The module SHALL be a single-outstanding FSM with states IDLE, ISSUE, COMMIT, WAIT_RES and RESP.
REQ-012 IDLE: cmd_ready_o=1 only in IDLE; on cmd_valid_i the FSM SHALL register instr, rs1, rs2 and the current id counter, then go to ISSUE.
REQ-013 ISSUE: x_issue_valid_o=1 with the registered payload held stable until x_issue_ready_i=1.
REQ-014 ISSUE with ready=1 and accept=0: go to RESP with status REJECTED and data, rd, we and exc all 0.
REQ-015 ISSUE with ready=1 and accept=1: the FSM SHALL register writeback and go to COMMIT.
REQ-016 COMMIT: x_commit_valid_o=1 for exactly one cycle with x_commit_id_o equal to the issued id and x_commit_kill_o equal to cmd_kill_i in that cycle.
REQ-017 COMMIT exit:
- kill=1 -> RESP with status KILLED
- else writeback=0 -> RESP with status OK and data 0
- else -> WAIT_RES.
REQ-018 WAIT_RES: x_result_ready_o=1 only in this state; the timeout counter SHALL clear on entry and increment each cycle.
REQ-019 WAIT_RES with result_valid=1 and id equal to the issued id: the FSM SHALL capture data, rd, we and exc, set status OK, and go to RESP.
REQ-020 WAIT_RES with result_valid=1 and a mismatched id: the beat SHALL be consumed and dropped, with no state change and no counter clear.
REQ-021 WAIT_RES with the counter at TimeoutCycles-1 and no matching result: go to RESP with status TIMEOUT and data 0.
REQ-022 WAIT_RES with a matching result in the timeout cycle: the result SHALL win and the status is OK.
REQ-023 RESP: rsp_valid_o=1 with response fields stable until rsp_ready_i=1; then the id counter SHALL increment modulo 2^IdWidth and the FSM returns to IDLE.
REQ-024 A new command SHALL be accepted no earlier than the cycle after the RESP handshake.
REQ-025 Minimum latency SHALL be as follows:
- cmd handshake at cycle 0
- x_issue_valid_o at cycle 1
- commit at cycle 2 (issue ready at cycle 1)
- for writeback=0, rsp_valid_o at cycle 3.
REQ-026 x_issue_valid_o, x_commit_valid_o, x_result_ready_o and rsp_valid_o SHALL be mutually exclusive.

Reset
REQ-027 With rst_ni=0 at a clock edge, the block SHALL enter IDLE, regardless of the current state, and clear to 0 the id counter, timeout counter, all payload and response registers, and all valid outputs.
REQ-028 The first cycle after reset SHALL have cmd_ready_o=1 and all other outputs 0.
REQ-029 A transaction in flight at reset SHALL be abandoned without issuing a commit or response.

Verification
REQ-030 Basic writeback: cmd instr=0x0000000B, rs1=5, rs2=7; issue accept=1, writeback=1; result id 0, data 12 -> rsp status 0, data 12; next transaction uses id 1.
REQ-031 Reject: issue ready=1, accept=0 -> no commit pulse; rsp status 1 one cycle later; id advances after the rsp handshake.
REQ-032 Kill: cmd_kill_i=1 in the commit cycle -> x_commit_kill_o=1; rsp status 2; x_result_ready_o never asserted.
REQ-033 Timeout: TimeoutCycles=16 and no result -> rsp status 3 exactly 16 cycles after WAIT_RES entry; a result with id 0 arriving in the last cycle -> status 0.
REQ-034 Stray result, id wrap and backpressure:
- a result with id 5 while waiting on id 2 is consumed and dropped
- after 8 transactions the id returns to 0
- rsp_ready_i held low for 10 cycles keeps rsp fields stable.
REQ-035 Reset during WAIT_RES: rst_ni=0 for one cycle -> IDLE, id 0, all valid outputs 0 the next cycle.
